// File: rtl/sorted_event_queue_if.sv
// Event-queue port bundle: producer/dispatcher side is the master, the queue is the slave.
interface sorted_event_queue_if #(
    parameter int DW   = 19,
    parameter int CNTW = 5
);
    logic            enq_i;
    logic            deq_i;
    logic [DW-1:0]   inp_data_i;
    logic [DW-1:0]   out_data_o;
    logic            out_vld_o;
    logic [CNTW-1:0] elem_cnt_o;
    logic            full_o;
    logic            empty_o;
    logic            overflow_o;
    logic            underflow_o;

    modport master (
        output enq_i, deq_i, inp_data_i,
        input  out_data_o, out_vld_o, elem_cnt_o, full_o, empty_o, overflow_o, underflow_o
    );

    modport slave (
        input  enq_i, deq_i, inp_data_i,
        output out_data_o, out_vld_o, elem_cnt_o, full_o, empty_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sorted_event_queue.sv
// Min-priority event queue as a register-based sorted array; one insert and one
// remove per cycle, stable among equal timestamps.
module sorted_event_queue #(
    parameter int DW    = 19,
    parameter int CW    = 16,
    parameter int DEPTH = 16,
    parameter int CNTW  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    sorted_event_queue_if.slave bus
);
    logic [DW-1:0]    data_q   [DEPTH];
    logic [DW-1:0]    data_d   [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             fullNow, emptyNow, doEnq, doDeq;
    logic [CW-1:0]    newKey;
    logic [DW-1:0]    srcData  [DEPTH];
    logic [DEPTH-1:0] srcVld, srcGt, insHere, shiftIn;

    assign fullNow  = (cnt_q == CNTW'(DEPTH));
    assign emptyNow = (cnt_q == '0);
    assign doDeq    = bus.deq_i && !emptyNow;
    assign doEnq    = bus.enq_i && (!fullNow || bus.deq_i);
    assign newKey   = bus.inp_data_i[CW-1:0];

    // A dequeue first shifts everything down one slot; the insert then works on that view.
    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_slot
        if (i < DEPTH - 1) begin : g_src
            assign srcData[i] = doDeq ? data_q[i+1] : data_q[i];
            assign srcVld[i]  = doDeq ? vld_q[i+1]  : vld_q[i];
        end else begin : g_srcLast
            assign srcData[i] = doDeq ? '0   : data_q[i];
            assign srcVld[i]  = doDeq ? 1'b0 : vld_q[i];
        end

        assign srcGt[i] = srcVld[i] && (srcData[i][CW-1:0] > newKey);

        // Strict greater-than keeps the newcomer behind every equal key.
        if (i == 0) begin : g_head
            assign insHere[i] = doEnq && (!srcVld[i] || srcGt[i]);
            assign shiftIn[i] = 1'b0;
            assign data_d[i]  = insHere[i] ? bus.inp_data_i : srcData[i];
        end else begin : g_body
            assign insHere[i] = doEnq && srcVld[i-1] && !srcGt[i-1] && (!srcVld[i] || srcGt[i]);
            assign shiftIn[i] = doEnq && srcGt[i-1];
            assign data_d[i]  = insHere[i] ? bus.inp_data_i :
                                shiftIn[i] ? srcData[i-1]  : srcData[i];
        end

        assign vld_d[i] = srcVld[i] | insHere[i] | shiftIn[i];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (doEnq && !doDeq) begin
            cnt_d = cnt_q + CNTW'(1);
        end else if (doDeq && !doEnq) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    assign ovf_d = ovf_q | (bus.enq_i && !bus.deq_i && fullNow);
    assign unf_d = unf_q | (bus.deq_i && emptyNow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.out_data_o  = vld_q[0] ? data_q[0] : '0;
    assign bus.out_vld_o   = vld_q[0];
    assign bus.elem_cnt_o  = cnt_q;
    assign bus.full_o      = fullNow;
    assign bus.empty_o     = emptyNow;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
endmodule

// File: doc/sorted_event_queue.md
Name: sorted_event_queue

Overview:
- Min-priority event queue that holds pending simulation events and sits directly upstream of the event dispatch and GVT logic.
- Accepts new events from the core-receive arbiter.
- Always presents the earliest-timestamp event on out_data for the dispatcher to pop.
- Implemented as a register-based sorted array with single-cycle systolic insert and remove, so one enqueue and one dequeue can complete in the same cycle.

Parameters:
DW, 19, total event width; bits [DW-1:CW] hold the LP id, bits [CW-1:0] hold the timestamp.
CW, 16, key width; the timestamp field used for ordering, compared unsigned.
DEPTH, 16, number of entries; must be at least 2.
CNTW, 5, width of elem_cnt; must satisfy 2^CNTW > DEPTH.

Ports:
clk  input  1  clock.
rst_n  input  1  asynchronous active-low reset.
enq  input  1  insert inp_data this cycle.
deq  input  1  remove the head entry this cycle.
inp_data  input  DW  event to insert.
out_data  output  DW  head entry (smallest key); all zeros when empty.
out_vld  output  1  high when the queue holds at least one entry.
elem_cnt  output  CNTW  number of valid entries.
full  output  1  elem_cnt == DEPTH.
empty  output  1  elem_cnt == 0.
overflow  output  1  sticky; set when an enqueue is dropped.
underflow  output  1  sticky; set when a dequeue is made on an empty queue.

Behaviour:
- Reset: rst_n low asynchronously clears the entry valid bits, entry data, elem_cnt, overflow and underflow.
  - Outputs after reset: out_data=0, out_vld=0, empty=1, full=0.
  - Reset asserted mid-operation discards all contents immediately; there is no drain.
- Storage: entries e[0..DEPTH-1], each with a valid bit.
  - Valid entries are contiguous from e[0].
  - Entries are ordered by key, ascending; e[0] is the head.
- Ordering rules:
  - The key is data[CW-1:0], compared unsigned.
  - Ties are stable: a new entry goes after all existing entries with an equal key (FIFO among equal timestamps).
- out_data, out_vld, full, empty and elem_cnt are registered-state derived with no combinational path from enq, deq or inp_data.
  - Latency: an entry enqueued in cycle N is visible on out_data in cycle N+1 if it becomes the head.
  - A dequeue in cycle N makes the next head visible in cycle N+1.
- Enqueue only (enq=1, deq=0, not full):
  - Each slot i compares its key with the new key.
  - Slot i loads inp_data if e[i-1] <= new < e[i] (or e[i] is invalid).
  - Slot i loads e[i-1] if e[i-1] > new.
  - Otherwise slot i holds.
  - elem_cnt increments.
- Dequeue only (enq=0, deq=1, not empty): every slot i loads e[i+1], the last slot is invalidated, and elem_cnt decrements.
- Simultaneous enq and deq, not empty:
  - The head is removed and the new entry is inserted in one cycle.
  - The result is the sorted merge of e[1..cnt-1] and inp_data.
  - elem_cnt is unchanged. This is permitted when full.
- Simultaneous enq and deq, empty:
  - underflow is set.
  - inp_data is inserted as the head and elem_cnt becomes 1.
- Enqueue alone when full: inp_data is dropped, overflow is set, and contents are unchanged.
- Dequeue alone when empty: no state change except underflow is set.
- overflow and underflow stay set until reset.
- Wrap-around: none. Timestamps are absolute and the comparison does not wrap; the producer guarantees keys never wrap within a run.

Test Plan:
- Reset then idle:
  - Hold rst_n low for 2 cycles, release.
  - Required: out_vld=0, empty=1, elem_cnt=0, out_data=0, overflow=0, underflow=0.
- Out-of-order insert:
  - Enqueue keys 40, 10, 30, 20 (LP ids 1, 2, 3, 4) on consecutive cycles.
  - Required: elem_cnt=4.
  - Dequeues on the next 4 cycles present keys 10, 20, 30, 40 with LP ids 2, 4, 3, 1.
  - Afterwards empty=1.
- Tie stability:
  - Enqueue key 5 with LP id 0, then key 5 with LP id 7, then key 3 with LP id 2.
  - Required dequeue order: (2,3), (0,5), (7,5).
- Simultaneous enq and deq:
  - Queue holds keys 10, 20.
  - Assert enq(15) and deq together for one cycle.
  - Required next cycle: out_data key 15, elem_cnt=2; then 15, 20 on the following dequeues.
- Full and overflow:
  - Enqueue 16 entries with keys 100..115.
  - Required: full=1, elem_cnt=16.
  - Enqueue key 1: dropped, overflow=1, head still 100.
  - enq(1) with deq: head becomes 1, elem_cnt stays 16, overflow stays 1.
- Empty, underflow and reset mid-run:
  - deq on empty: underflow=1, elem_cnt=0.
  - Load 3 entries, then pulse rst_n low mid-cycle.
  - Required: all flags and the count are cleared asynchronously, before the next clk edge.
